// File: rtl/game_sequencer.sv
// Game-flow controller: power/title/play/pause/over/done FSM, score timebase,
// level/speed/music selection and the 3-digit display code. All outputs registered.
module game_sequencer #(
   parameter int TICK_DIV     = 100000,
   parameter int SCORE_MAX    = 600,
   parameter int LEVEL_LEN    = 150,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        on_btn,
   input  logic        start_btn,
   input  logic        restart,
   input  logic        collision,
   input  logic        frame_start,
   output logic [2:0]  state,
   output logic        powered,
   output logic        running,
   output logic        gameover,
   output logic        complete,
   output logic [9:0]  score,
   output logic [1:0]  level,
   output logic [2:0]  speed,
   output logic [2:0]  mus_sel,
   output logic [11:0] disp_code,
   output logic        display_en
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [PW-1:0] PRESC_TC  = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_TC  = BW'(BLINK_FRAMES - 1);
   localparam logic [9:0]    SCORE_TOP = 10'(SCORE_MAX);

   typedef enum logic [2:0] {
      S_OFF = 3'd0, S_TITLE = 3'd1, S_PLAY = 3'd2,
      S_PAUSE = 3'd3, S_OVER = 3'd4, S_DONE = 3'd5
   } state_t;

   state_t        state_reg, state_next;
   logic [1:0]    sync1_reg, sync2_reg, prev_reg;
   logic [PW-1:0] presc_reg, presc_next;
   logic [9:0]    score_reg, score_next;
   logic [11:0]   bcd_reg, bcd_next, bcd_inc;
   logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
   logic          blink_reg, blink_next;
   logic [1:0]    level_reg, level_next;
   logic [2:0]    speed_reg, speed_next, mus_reg, mus_next;
   logic [11:0]   disp_reg, disp_next;
   logic [2:0]    carry_chain;
   logic          power_edge, start_edge, clear, counting, tick;

   // bit 0 = power button, bit 1 = start button
   assign power_edge = prev_reg[0] & ~sync2_reg[0];
   assign start_edge = prev_reg[1] & ~sync2_reg[1];

   // Decimal increment of the BCD score with carry ripple across the digits
   assign carry_chain[0] = 1'b1;
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
         logic [3:0] digit;
         assign digit = bcd_reg[gi*4 +: 4];
         assign bcd_inc[gi*4 +: 4] = carry_chain[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1)
                                                     : digit;
         if (gi < 2) begin : g_carry
            assign carry_chain[gi+1] = carry_chain[gi] & (digit == 4'd9);
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      if (power_edge) begin
         state_next = (state_reg == S_OFF) ? S_TITLE : S_OFF;
      end else begin
         case (state_reg)
            S_TITLE: if (start_edge) state_next = S_PLAY;
            S_PLAY: begin
               if (restart)                       state_next = S_TITLE;
               else if (collision)                state_next = S_OVER;
               else if (score_reg == SCORE_TOP)   state_next = S_DONE;
               else if (start_edge)               state_next = S_PAUSE;
            end
            S_PAUSE: begin
               if (restart)         state_next = S_TITLE;
               else if (start_edge) state_next = S_PLAY;
            end
            S_OVER, S_DONE: if (restart) state_next = S_TITLE;
            default: state_next = S_OFF;
         endcase
      end

      // Leaving PLAY on this edge freezes the prescaler, so a resume keeps the phase.
      clear    = (state_next == S_OFF) || (state_next == S_TITLE) || (state_reg == S_TITLE);
      counting = (state_reg == S_PLAY) && (state_next == S_PLAY);
      tick     = counting && (presc_reg == PRESC_TC);

      presc_next = presc_reg;
      score_next = score_reg;
      bcd_next   = bcd_reg;
      if (clear) begin
         presc_next = '0;
         score_next = '0;
         bcd_next   = '0;
      end else if (counting) begin
         presc_next = tick ? '0 : presc_reg + 1'b1;
         if (tick && (score_reg < SCORE_TOP)) begin
            score_next = score_reg + 10'd1;
            bcd_next   = bcd_inc;
         end
      end

      blink_cnt_next = '0;
      blink_next     = 1'b0;
      if ((state_reg == S_OVER) && (state_next == S_OVER)) begin
         blink_cnt_next = blink_cnt_reg;
         blink_next     = blink_reg;
         if (frame_start) begin
            if (blink_cnt_reg == BLINK_TC) begin
               blink_cnt_next = '0;
               blink_next     = ~blink_reg;
            end else begin
               blink_cnt_next = blink_cnt_reg + 1'b1;
            end
         end
      end

      if (score_next >= 10'(3 * LEVEL_LEN))      level_next = 2'd3;
      else if (score_next >= 10'(2 * LEVEL_LEN)) level_next = 2'd2;
      else if (score_next >= 10'(LEVEL_LEN))     level_next = 2'd1;
      else                                       level_next = 2'd0;

      speed_next = (state_next == S_PLAY) ? {1'b0, level_next} + 3'd1 : 3'd0;
      mus_next   = (state_next == S_PLAY) ? {1'b0, level_next} : 3'd4;

      case (state_next)
         S_TITLE, S_PLAY, S_PAUSE: disp_next = bcd_next;
         S_OVER:                   disp_next = blink_next ? bcd_next : 12'hDEF;
         S_DONE:                   disp_next = 12'hABC;
         default:                  disp_next = 12'h000;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_reg     <= 2'b11;
         sync2_reg     <= 2'b11;
         prev_reg      <= 2'b11;
         state_reg     <= S_OFF;
         presc_reg     <= '0;
         score_reg     <= '0;
         bcd_reg       <= '0;
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b0;
         level_reg     <= 2'd0;
         speed_reg     <= 3'd0;
         mus_reg       <= 3'd4;
         disp_reg      <= 12'h000;
         powered       <= 1'b0;
         running       <= 1'b0;
         gameover      <= 1'b0;
         complete      <= 1'b0;
         display_en    <= 1'b0;
      end else begin
         sync1_reg     <= {start_btn, on_btn};
         sync2_reg     <= sync1_reg;
         prev_reg      <= sync2_reg;
         state_reg     <= state_next;
         presc_reg     <= presc_next;
         score_reg     <= score_next;
         bcd_reg       <= bcd_next;
         blink_cnt_reg <= blink_cnt_next;
         blink_reg     <= blink_next;
         level_reg     <= level_next;
         speed_reg     <= speed_next;
         mus_reg       <= mus_next;
         disp_reg      <= disp_next;
         powered       <= (state_next != S_OFF);
         running       <= (state_next == S_PLAY);
         gameover      <= (state_next == S_OVER);
         complete      <= (state_next == S_DONE);
         display_en    <= (state_next != S_OFF);
      end
   end

   assign state     = state_reg;
   assign score     = score_reg;
   assign level     = level_reg;
   assign speed     = speed_reg;
   assign mus_sel   = mus_reg;
   assign disp_code = disp_reg;
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_game_sequencer;
   logic        clock = 1'b0;
   logic        reset, on_btn, start_btn, restart, collision, frame_start;
   logic [2:0]  state;
   logic        powered, running, gameover, complete, display_en;
   logic [9:0]  score;
   logic [1:0]  level;
   logic [2:0]  speed, mus_sel;
   logic [11:0] disp_code;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    sel;
      int    exp;
   } chk_t;
   chk_t q[$];

   localparam int F_STATE = 0, F_SCORE = 1, F_LEVEL = 2, F_SPEED = 3,
                  F_MUS = 4, F_DISP = 5, F_FLAGS = 6;

   game_sequencer #(
      .TICK_DIV(4), .SCORE_MAX(600), .LEVEL_LEN(150), .BLINK_FRAMES(2)
   ) dut (
      .clock(clock), .reset(reset), .on_btn(on_btn), .start_btn(start_btn),
      .restart(restart), .collision(collision), .frame_start(frame_start),
      .state(state), .powered(powered), .running(running), .gameover(gameover),
      .complete(complete), .score(score), .level(level), .speed(speed),
      .mus_sel(mus_sel), .disp_code(disp_code), .display_en(display_en)
   );

   always #5 clock = ~clock;

   function automatic int field(input int sel);
      case (sel)
         F_STATE: return int'(state);
         F_SCORE: return int'(score);
         F_LEVEL: return int'(level);
         F_SPEED: return int'(speed);
         F_MUS:   return int'(mus_sel);
         F_DISP:  return int'(disp_code);
         default: return int'({powered, running, gameover, complete, display_en});
      endcase
   endfunction

   // Monitor: compare every queued expectation against the outputs at the negedge
   always @(negedge clock) begin
      while (q.size() > 0) begin
         chk_t c;
         int   act;
         c   = q.pop_front();
         act = field(c.sel);
         checks++;
         if (act != c.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", c.name, act, c.exp, $time);
         end else begin
            $display("check %s: 0x%0h ok", c.name, act);
         end
      end
   end

   task automatic expect_out(input string name, input int sel, input int val);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = val;
      q.push_back(c);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press_on();
      on_btn = 1'b0; cyc(1); on_btn = 1'b1; cyc(2);
   endtask

   task automatic press_start();
      start_btn = 1'b0; cyc(1); start_btn = 1'b1; cyc(2);
   endtask

   task automatic pulse_restart();
      restart = 1'b1; cyc(1); restart = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1; cyc(1); frame_start = 1'b0; cyc(1);
   endtask

   task automatic expect_reset_vals(input string tag);
      expect_out({tag, "_state"}, F_STATE, 0);
      expect_out({tag, "_score"}, F_SCORE, 0);
      expect_out({tag, "_level"}, F_LEVEL, 0);
      expect_out({tag, "_speed"}, F_SPEED, 0);
      expect_out({tag, "_mus"},   F_MUS,   4);
      expect_out({tag, "_disp"},  F_DISP,  12'h000);
      expect_out({tag, "_flags"}, F_FLAGS, 5'b00000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; on_btn = 1'b1; start_btn = 1'b1;
      restart = 1'b0; collision = 1'b0; frame_start = 1'b0;
      cyc(3);
      expect_reset_vals("rst");
      reset = 1'b1;
      cyc(2);

      // Power on: state changes on the third edge after the fall
      on_btn = 1'b0;
      cyc(2);
      expect_out("pwr_early_state", F_STATE, 0);
      cyc(1);
      on_btn = 1'b1;
      expect_out("pwr_state", F_STATE, 1);
      expect_out("pwr_flags", F_FLAGS, 5'b10001);
      expect_out("pwr_disp",  F_DISP,  12'h000);

      // Play through the first level boundary
      press_start();
      expect_out("play_state", F_STATE, 2);
      expect_out("play_score0", F_SCORE, 0);
      cyc(596);
      expect_out("s149_score", F_SCORE, 149);
      expect_out("s149_level", F_LEVEL, 0);
      expect_out("s149_speed", F_SPEED, 1);
      expect_out("s149_disp",  F_DISP,  12'h149);
      cyc(4);
      expect_out("s150_score", F_SCORE, 150);
      expect_out("s150_level", F_LEVEL, 1);
      expect_out("s150_speed", F_SPEED, 2);
      expect_out("s150_mus",   F_MUS,   1);
      expect_out("s150_disp",  F_DISP,  12'h150);
      expect_out("s150_flags", F_FLAGS, 5'b11001);
      pulse_restart();
      expect_out("rs1_state", F_STATE, 1);
      expect_out("rs1_score", F_SCORE, 0);
      expect_out("rs1_disp",  F_DISP,  12'h000);

      // Collision at score 37, then blink
      press_start();
      cyc(148);
      expect_out("pre_col_score", F_SCORE, 37);
      collision = 1'b1; cyc(1); collision = 1'b0;
      expect_out("col_state", F_STATE, 4);
      expect_out("col_score", F_SCORE, 37);
      expect_out("col_flags", F_FLAGS, 5'b10101);
      expect_out("col_disp",  F_DISP,  12'hDEF);
      expect_out("col_mus",   F_MUS,   4);
      frame();
      expect_out("blink1_disp", F_DISP, 12'hDEF);
      frame();
      expect_out("blink2_disp", F_DISP, 12'h037);
      frame();
      frame();
      expect_out("blink4_disp", F_DISP, 12'hDEF);
      expect_out("over_score",  F_SCORE, 37);
      pulse_restart();
      expect_out("rs2_state", F_STATE, 1);
      expect_out("rs2_score", F_SCORE, 0);

      // Play to completion
      press_start();
      cyc(2400);
      expect_out("s600_state", F_STATE, 2);
      expect_out("s600_score", F_SCORE, 600);
      expect_out("s600_disp",  F_DISP,  12'h600);
      cyc(1);
      expect_out("done_state", F_STATE, 5);
      expect_out("done_flags", F_FLAGS, 5'b10011);
      expect_out("done_disp",  F_DISP,  12'hABC);
      expect_out("done_level", F_LEVEL, 3);
      expect_out("done_speed", F_SPEED, 0);
      collision = 1'b1; cyc(1); collision = 1'b0;
      cyc(20);
      expect_out("done_hold_score", F_SCORE, 600);
      expect_out("done_hold_state", F_STATE, 5);
      pulse_restart();
      expect_out("rs3_state", F_STATE, 1);

      // Pause at score 10 with the prescaler at 2, then resume
      press_start();
      cyc(40);
      expect_out("p10_score", F_SCORE, 10);
      press_start();
      expect_out("pause_state", F_STATE, 3);
      expect_out("pause_score", F_SCORE, 10);
      expect_out("pause_speed", F_SPEED, 0);
      cyc(100);
      expect_out("pause_hold_score", F_SCORE, 10);
      collision = 1'b1; cyc(1); collision = 1'b0;
      expect_out("pause_col_state", F_STATE, 3);
      press_start();
      expect_out("resume_state", F_STATE, 2);
      cyc(1);
      expect_out("resume_c1_score", F_SCORE, 10);
      cyc(1);
      expect_out("resume_c2_score", F_SCORE, 11);

      // Power edge and collision together: power wins
      on_btn = 1'b0; cyc(1); on_btn = 1'b1; cyc(1);
      collision = 1'b1; cyc(1); collision = 1'b0;
      expect_out("pwroff_state", F_STATE, 0);
      expect_out("pwroff_score", F_SCORE, 0);
      expect_out("pwroff_flags", F_FLAGS, 5'b00000);
      expect_out("pwroff_disp",  F_DISP,  12'h000);

      // Reset mid-PLAY
      press_on();
      press_start();
      cyc(50);
      expect_out("mid_score", F_SCORE, 12);
      reset = 1'b0; cyc(1);
      expect_reset_vals("rst2");
      reset = 1'b1;
      cyc(5);
      expect_out("post_rst_state", F_STATE, 0);

      cyc(2);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central game-flow controller for the VGA racing game. It owns the power/title/play/pause/game-over/complete state machine, the 0–600 score timebase, level/speed/music selection and the 3-digit display code. The sprite-motion, collision-detect and display-mux logic consume its outputs instead of keeping their own `inicio`/`encendido`/`gameover` flags.

## Interface
- TICK_DIV, 100000: clock cycles per score tick (500 Hz at 50 MHz).
- SCORE_MAX, 600: final score; reaching it completes the game.
- LEVEL_LEN, 150: score points per level.
- BLINK_FRAMES, 30: frames per half-period of the game-over display blink.

- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- on_btn  in  1  raw power button; falling edge toggles power
- start_btn  in  1  raw start button; falling edge starts, pauses or resumes play
- restart  in  1  synchronous, active-high; returns to TITLE from PLAY, PAUSE, OVER or DONE
- collision  in  1  synchronous car-overlap flag from the pixel pipeline
- frame_start  in  1  one-cycle pulse per VGA frame
- state  out  3  OFF=0, TITLE=1, PLAY=2, PAUSE=3, OVER=4, DONE=5
- powered, running, gameover, complete  out  1 each  decoded state flags: not OFF, PLAY, OVER, DONE
- score  out  10  binary score, 0..SCORE_MAX
- level  out  2  min(score/LEVEL_LEN, 3)
- speed  out  3  level+1 in PLAY, else 0
- mus_sel  out  3  level in PLAY, 4 (silence) otherwise
- disp_code  out  12  three nibble codes to the 7-segment decoder
- display_en  out  1  0 only in OFF

## Operation
- Buttons:
  - on_btn and start_btn each pass through a 2-flop synchronizer and then a previous-value flop.
  - An edge is `prev & ~sync`.
  - Synchronizer and previous-value flops reset to 1, so no edge fires out of reset.
- Transitions, evaluated in priority order: power edge > restart > collision > score==SCORE_MAX > start edge.
  - Any state, power edge: OFF → TITLE; any other state → OFF.
  - TITLE, start edge: → PLAY. Score, BCD and prescaler are cleared on entry.
  - PLAY:
    - collision → OVER.
    - score==SCORE_MAX → DONE.
    - start edge → PAUSE.
    - restart → TITLE.
  - PAUSE:
    - start edge → PLAY.
    - restart → TITLE.
    - collision is ignored.
  - OVER, restart → TITLE.
  - DONE, restart → TITLE.
  - Any transition to TITLE or OFF clears score, BCD, prescaler and blink state.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1 only in PLAY.
  - It holds its value in PAUSE, so resuming keeps the tick phase.
  - At terminal count: score+1 and BCD+1, with a decimal-carry ripple across 3 digits.
  - Score saturates at SCORE_MAX and never wraps.
- Level boundaries are inclusive at the lower end: 0–149 → 0, 150–299 → 1, 300–449 → 2, ≥450 → 3.
- disp_code:
  - TITLE, PLAY, PAUSE: BCD score.
  - DONE: 12'hABC.
  - OVER: alternates between 12'hDEF and BCD score. The alternation toggles every BLINK_FRAMES frame_start pulses, starting with 12'hDEF on entry.
  - OFF: 12'h000.
- All outputs are registered.
- Reset values:
  - state OFF; score 0; level 0; speed 0.
  - mus_sel 4; disp_code 12'h000.
  - All 1-bit flags 0.

## Timing
- Button falling edge between clock edges k-1 and k: state updates at edge k+2.
- collision high sampled at edge k: state = OVER after edge k; gameover = 1 after the same edge.
- Score tick: score, BCD and level update on the same edge.
  - A tick that makes score == SCORE_MAX moves the state to DONE one edge later.
- Score freezes in OVER, PAUSE and DONE.
- Simultaneous events resolve by the priority order in Operation. A power edge in PLAY together with collision → OFF.
- reset low on any edge: all registers take reset values at that edge, regardless of state or pending edges.

## Test plan
- Use TICK_DIV=4, BLINK_FRAMES=2 throughout.
- Release reset, then fall on_btn → state=1 at the 3rd edge after the fall; powered=1, display_en=1, disp_code=12'h000.
- Start edge, then 600 cycles in PLAY → score=150, level=1, speed=2, mus_sel=1, disp_code=12'h150. At score 149: level=0.
- Collision at score 37 → state=4 next edge, score held at 37. disp_code is 12'hDEF for 2 frame_start pulses, then 12'h037. Restart → state=1, score=0.
- Play to 600 → state=5, complete=1, disp_code=12'hABC. Further cycles and a collision pulse leave score=600.
- Pause/resume:
  - Start edge at score 10 with prescaler=2 → state=3, score frozen for 100 cycles.
  - Resume → next tick after 2 cycles.
  - Collision while paused: no effect.
- Power edge and collision in the same cycle in PLAY → state=0, score=0.
- reset low mid-PLAY → all outputs at reset values next edge.
